// File: rtl/csr_file_pkg.sv
// ----------------------------------------------------------------------------
// csr_file_pkg
// Shared constants and types for the machine-mode CSR file:
//   - CSR_Addr_* : 12-bit CSR addresses decoded by csr_file
//   - fixed read-only values (misa, mvendorid, marchid) and the mstatus reset
//   - ZeroWord / Enable / Disable helpers
//   - csr_wr_t   : one write port after acceptance and data fix-up
//   - csr_writable / csr_addr_ok / csr_wdata_fix : write decode helpers
// ----------------------------------------------------------------------------
package csr_file_pkg;

   localparam logic [11:0] CSR_Addr_Mstatus   = 12'h300;
   localparam logic [11:0] CSR_Addr_Misa      = 12'h301;
   localparam logic [11:0] CSR_Addr_Mie       = 12'h304;
   localparam logic [11:0] CSR_Addr_Mtvec     = 12'h305;
   localparam logic [11:0] CSR_Addr_Mscratch  = 12'h340;
   localparam logic [11:0] CSR_Addr_Mepc      = 12'h341;
   localparam logic [11:0] CSR_Addr_Mcause    = 12'h342;
   localparam logic [11:0] CSR_Addr_Mip       = 12'h344;
   localparam logic [11:0] CSR_Addr_Mcycle    = 12'hB00;
   localparam logic [11:0] CSR_Addr_Minstret  = 12'hB02;
   localparam logic [11:0] CSR_Addr_Mcycleh   = 12'hB80;
   localparam logic [11:0] CSR_Addr_Minstreth = 12'hB82;
   localparam logic [11:0] CSR_Addr_Mvendorid = 12'hF11;
   localparam logic [11:0] CSR_Addr_Marchid   = 12'hF12;
   localparam logic [11:0] CSR_Addr_Mhartid   = 12'hF14;

   localparam logic [31:0] MISA_VALUE      = 32'h4000_0100;
   localparam logic [31:0] MVENDORID_VALUE = 32'h0000_0000;
   localparam logic [31:0] MARCHID_VALUE   = 32'h0000_0000;
   localparam logic [31:0] MSTATUS_RESET   = 32'h0000_1800;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;
   localparam logic        Enable   = 1'b1;
   localparam logic        Disable  = 1'b0;

   // A write port after legality check and priority resolution.
   typedef struct packed {
      logic        acc;
      logic [31:0] addr;
      logic [31:0] data;
   } csr_wr_t;

   // Registers that hold state; everything else (read-only or unimplemented)
   // silently drops writes.
   function automatic logic csr_writable(input logic [11:0] a);
      case (a)
         CSR_Addr_Mstatus, CSR_Addr_Mie, CSR_Addr_Mtvec, CSR_Addr_Mscratch,
         CSR_Addr_Mepc, CSR_Addr_Mcause, CSR_Addr_Mcycle, CSR_Addr_Minstret,
         CSR_Addr_Mcycleh, CSR_Addr_Minstreth: csr_writable = Enable;
         default:                              csr_writable = Disable;
      endcase
   endfunction

   // Full 32-bit address check: the upper 20 bits must be clear.
   function automatic logic csr_addr_ok(input logic [31:0] a);
      csr_addr_ok = (a[31:12] == 20'h0) && csr_writable(a[11:0]);
   endfunction

   // mepc is always word aligned; the same fixed-up value feeds the bypass.
   function automatic logic [31:0] csr_wdata_fix(input logic [31:0] a,
                                                 input logic [31:0] d);
      if (a == {20'h0, CSR_Addr_Mepc}) csr_wdata_fix = {d[31:2], 2'b00};
      else                             csr_wdata_fix = d;
   endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// ----------------------------------------------------------------------------
// csr_counter64
// 64-bit free-running counter with a per-half write port.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   inc        : increment enable for this cycle
//   we_lo      : load count[31:0]  from wdata[31:0]
//   we_hi      : load count[63:32] from wdata[63:32]
//   wdata      : load data, {hi, lo}
//   count      : current value
// Any write takes precedence over the increment for the whole 64 bits, so a
// low-half load never carries into the high half on that edge.
// ----------------------------------------------------------------------------
module csr_counter64 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        we_lo,
   input  logic        we_hi,
   input  logic [63:0] wdata,
   output logic [63:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 64'h0;
      end else if (we_lo || we_hi) begin
         if (we_lo) count[31:0]  <= wdata[31:0];
         if (we_hi) count[63:32] <= wdata[63:32];
      end else if (inc) begin
         count <= count + 64'h1;
      end
   end

endmodule

// File: rtl/csr_file.sv
// ----------------------------------------------------------------------------
// csr_file
// Machine-mode CSR register file for the RV32 core.
//   clk, rst_n          : clock, asynchronous active-low reset
//   ex_we_i/_waddr_i/_wdata_i    : execute-stage CSR write port
//   int_we_i/_waddr_i/_wdata_i   : interrupt-controller write port (wins on
//                                  an address collision)
//   raddr_i / rdata_o   : combinational read, write-first bypass
//   retire_i            : one instruction retired (minstret increment)
//   int_i               : external interrupt lines, visible in mip only
//   mtvec_o, mepc_o, mstatus_o : registered values (not bypassed)
//   global_int_en_o     : mstatus.MIE
// Parameters: MTVEC_RESET (mtvec reset value), MHARTID (mhartid value).
// ----------------------------------------------------------------------------
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_we_i,
   input  logic [31:0] ex_waddr_i,
   input  logic [31:0] ex_wdata_i,
   input  logic        int_we_i,
   input  logic [31:0] int_waddr_i,
   input  logic [31:0] int_wdata_i,
   input  logic [31:0] raddr_i,
   output logic [31:0] rdata_o,
   input  logic        retire_i,
   input  logic [7:0]  int_i,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic [31:0] mstatus_o,
   output logic        global_int_en_o
);

   logic [31:0] mstatus_q, mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
   logic [31:0] mstatus_d, mie_d, mtvec_d, mscratch_d, mepc_d, mcause_d;

   logic        cyc_we_lo, cyc_we_hi, ins_we_lo, ins_we_hi;
   logic [63:0] cyc_wdata, ins_wdata;
   logic [63:0] mcycle_q, minstret_q;

   // wr[0] = execute port, wr[1] = interrupt port. Index order is priority
   // order in the decode loop below.
   csr_wr_t wr [2];

   // -------------------------------------------------------------------------
   // Port acceptance. An ex write to the same address as an accepted int write
   // is dropped outright, so it can neither commit nor appear on the bypass.
   // -------------------------------------------------------------------------
   always_comb begin
      wr[0].addr = ex_waddr_i;
      wr[0].data = csr_wdata_fix(ex_waddr_i, ex_wdata_i);
      wr[0].acc  = ex_we_i && csr_addr_ok(ex_waddr_i);
      wr[1].addr = int_waddr_i;
      wr[1].data = csr_wdata_fix(int_waddr_i, int_wdata_i);
      wr[1].acc  = int_we_i && csr_addr_ok(int_waddr_i);
      if (wr[1].acc && (wr[1].addr == wr[0].addr)) wr[0].acc = Disable;
   end

   // -------------------------------------------------------------------------
   // Write decode into next-state values and counter half-writes.
   // -------------------------------------------------------------------------
   always_comb begin
      mstatus_d  = mstatus_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      cyc_we_lo  = Disable;
      cyc_we_hi  = Disable;
      ins_we_lo  = Disable;
      ins_we_hi  = Disable;
      cyc_wdata  = 64'h0;
      ins_wdata  = 64'h0;
      for (int p = 0; p < 2; p++) begin
         if (wr[p].acc) begin
            case (wr[p].addr[11:0])
               CSR_Addr_Mstatus:  mstatus_d  = wr[p].data;
               CSR_Addr_Mie:      mie_d      = wr[p].data;
               CSR_Addr_Mtvec:    mtvec_d    = wr[p].data;
               CSR_Addr_Mscratch: mscratch_d = wr[p].data;
               CSR_Addr_Mepc:     mepc_d     = wr[p].data;
               CSR_Addr_Mcause:   mcause_d   = wr[p].data;
               CSR_Addr_Mcycle: begin
                  cyc_we_lo        = Enable;
                  cyc_wdata[31:0]  = wr[p].data;
               end
               CSR_Addr_Mcycleh: begin
                  cyc_we_hi        = Enable;
                  cyc_wdata[63:32] = wr[p].data;
               end
               CSR_Addr_Minstret: begin
                  ins_we_lo        = Enable;
                  ins_wdata[31:0]  = wr[p].data;
               end
               CSR_Addr_Minstreth: begin
                  ins_we_hi        = Enable;
                  ins_wdata[63:32] = wr[p].data;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mstatus_q  <= MSTATUS_RESET;
         mie_q      <= ZeroWord;
         mtvec_q    <= MTVEC_RESET;
         mscratch_q <= ZeroWord;
         mepc_q     <= ZeroWord;
         mcause_q   <= ZeroWord;
      end else begin
         mstatus_q  <= mstatus_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
      end
   end

   // -------------------------------------------------------------------------
   // Counters
   // -------------------------------------------------------------------------
   csr_counter64 u_mcycle (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (Enable),
      .we_lo (cyc_we_lo),
      .we_hi (cyc_we_hi),
      .wdata (cyc_wdata),
      .count (mcycle_q)
   );

   csr_counter64 u_minstret (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (retire_i),
      .we_lo (ins_we_lo),
      .we_hi (ins_we_hi),
      .wdata (ins_wdata),
      .count (minstret_q)
   );

   // -------------------------------------------------------------------------
   // Read mux with write-first bypass. The int port is checked last so it
   // overrides; in practice both can only match when ex was already dropped.
   // -------------------------------------------------------------------------
   logic [31:0] rdata_reg;

   always_comb begin
      rdata_reg = ZeroWord;
      if (raddr_i[31:12] == 20'h0) begin
         case (raddr_i[11:0])
            CSR_Addr_Mstatus:   rdata_reg = mstatus_q;
            CSR_Addr_Misa:      rdata_reg = MISA_VALUE;
            CSR_Addr_Mie:       rdata_reg = mie_q;
            CSR_Addr_Mtvec:     rdata_reg = mtvec_q;
            CSR_Addr_Mscratch:  rdata_reg = mscratch_q;
            CSR_Addr_Mepc:      rdata_reg = mepc_q;
            CSR_Addr_Mcause:    rdata_reg = mcause_q;
            CSR_Addr_Mip:       rdata_reg = {24'h0, int_i};
            CSR_Addr_Mcycle:    rdata_reg = mcycle_q[31:0];
            CSR_Addr_Minstret:  rdata_reg = minstret_q[31:0];
            CSR_Addr_Mcycleh:   rdata_reg = mcycle_q[63:32];
            CSR_Addr_Minstreth: rdata_reg = minstret_q[63:32];
            CSR_Addr_Mvendorid: rdata_reg = MVENDORID_VALUE;
            CSR_Addr_Marchid:   rdata_reg = MARCHID_VALUE;
            CSR_Addr_Mhartid:   rdata_reg = MHARTID;
            default:            rdata_reg = ZeroWord;
         endcase
      end
   end

   always_comb begin
      rdata_o = rdata_reg;
      if (wr[0].acc && (wr[0].addr == raddr_i)) rdata_o = wr[0].data;
      if (wr[1].acc && (wr[1].addr == raddr_i)) rdata_o = wr[1].data;
   end

   assign mtvec_o         = mtvec_q;
   assign mepc_o          = mepc_q;
   assign mstatus_o       = mstatus_q;
   assign global_int_en_o = mstatus_q[3];

endmodule

// File: tb/tb_csr_file.sv
// ----------------------------------------------------------------------------
// tb_csr_file
// Table-driven bench for csr_file. Each record drives one cycle of inputs and
// carries the expected rdata_o plus the expected registered side outputs for
// that cycle. Records are pushed to a scoreboard when driven and popped and
// compared once the combinational outputs settle, before the next clock edge.
// ----------------------------------------------------------------------------
module tb_csr_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_we_i, int_we_i, retire_i;
   logic [31:0] ex_waddr_i, ex_wdata_i, int_waddr_i, int_wdata_i, raddr_i;
   logic [31:0] rdata_o, mtvec_o, mepc_o, mstatus_o;
   logic [7:0]  int_i;
   logic        global_int_en_o;

   int checks = 0;
   int errors = 0;
   int cyc;

   always #5 clk = ~clk;

   // Clock edges since the last reset release; mcycle must track this.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   csr_file #(.MTVEC_RESET(32'h0000_0000), .MHARTID(32'h0000_0000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ex_we_i         (ex_we_i),
      .ex_waddr_i      (ex_waddr_i),
      .ex_wdata_i      (ex_wdata_i),
      .int_we_i        (int_we_i),
      .int_waddr_i     (int_waddr_i),
      .int_wdata_i     (int_wdata_i),
      .raddr_i         (raddr_i),
      .rdata_o         (rdata_o),
      .retire_i        (retire_i),
      .int_i           (int_i),
      .mtvec_o         (mtvec_o),
      .mepc_o          (mepc_o),
      .mstatus_o       (mstatus_o),
      .global_int_en_o (global_int_en_o)
   );

   typedef struct {
      string       name;
      logic        ex_we;
      logic [31:0] ex_addr, ex_data;
      logic        int_we;
      logic [31:0] int_addr, int_data;
      logic [31:0] raddr;
      logic [7:0]  irq;
      logic        retire;
      logic [31:0] exp_rdata, exp_mtvec, exp_mepc, exp_mstatus;
      logic        exp_gie;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   // Expected side outputs for the hand-written sequences.
   logic [31:0] s_mtvec, s_mepc, s_mstatus;
   logic        s_gie;

   function automatic vec_t mk(string n,
                               logic ew, logic [31:0] ea, logic [31:0] ed,
                               logic iw, logic [31:0] ia, logic [31:0] id,
                               logic [31:0] ra, logic [7:0] irq, logic ret,
                               logic [31:0] er, logic [31:0] etv,
                               logic [31:0] eep, logic [31:0] est, logic eg);
      vec_t v;
      v.name = n; v.ex_we = ew; v.ex_addr = ea; v.ex_data = ed;
      v.int_we = iw; v.int_addr = ia; v.int_data = id;
      v.raddr = ra; v.irq = irq; v.retire = ret;
      v.exp_rdata = er; v.exp_mtvec = etv; v.exp_mepc = eep;
      v.exp_mstatus = est; v.exp_gie = eg;
      return v;
   endfunction

   // Hand-sequence record using the current s_* side expectations.
   function automatic vec_t hs(string n,
                               logic ew, logic [31:0] ea, logic [31:0] ed,
                               logic iw, logic [31:0] ia, logic [31:0] id,
                               logic [31:0] ra, logic ret, logic [31:0] er);
      return mk(n, ew, ea, ed, iw, ia, id, ra, 8'h00, ret, er,
                s_mtvec, s_mepc, s_mstatus, s_gie);
   endfunction

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask

   task automatic check_out();
      vec_t e;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty actual=0 expected=1");
         return;
      end
      e = sb.pop_front();
      chk({e.name, ".rdata"},   rdata_o,   e.exp_rdata);
      chk({e.name, ".mtvec"},   mtvec_o,   e.exp_mtvec);
      chk({e.name, ".mepc"},    mepc_o,    e.exp_mepc);
      chk({e.name, ".mstatus"}, mstatus_o, e.exp_mstatus);
      chk({e.name, ".gie"},     {31'h0, global_int_en_o}, {31'h0, e.exp_gie});
   endtask

   // Called just after a falling edge: drive, settle, compare, then let the
   // rising edge commit and return at the next falling edge.
   task automatic run(input vec_t v);
      ex_we_i = v.ex_we;   ex_waddr_i = v.ex_addr;   ex_wdata_i = v.ex_data;
      int_we_i = v.int_we; int_waddr_i = v.int_addr; int_wdata_i = v.int_data;
      raddr_i = v.raddr;   int_i = v.irq;            retire_i = v.retire;
      sb.push_back(v);
      #1;
      check_out();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      ex_we_i = 1'b0;  ex_waddr_i = '0;  ex_wdata_i = '0;
      int_we_i = 1'b0; int_waddr_i = '0; int_wdata_i = '0;
      raddr_i = '0;    int_i = '0;       retire_i = 1'b0;
   endtask

   localparam logic [31:0] A_MST = 32'h300, A_MISA = 32'h301, A_MIE = 32'h304,
                           A_MTV = 32'h305, A_MSC = 32'h340, A_MEPC = 32'h341,
                           A_MCA = 32'h342, A_MIP = 32'h344, A_CYC = 32'hB00,
                           A_INS = 32'hB02, A_CYCH = 32'hB80, A_INSH = 32'hB82;

   initial begin
      idle_inputs();
      rst_n = 1'b0;

      // ---------------------------------------------------------------------
      //            name        ex_we addr   data          int_we addr   data            raddr    irq   ret rdata          mtvec          mepc           mstatus   gie
      tbl.push_back(mk("rst_mst",  0, 0,      0,            0, 0,      0,            A_MST,   8'h0, 0, 32'h1800,      0,             0,             32'h1800, 0));
      tbl.push_back(mk("rst_mtv",  0, 0,      0,            0, 0,      0,            A_MTV,   8'h0, 0, 32'h0,         0,             0,             32'h1800, 0));
      tbl.push_back(mk("rst_misa", 0, 0,      0,            0, 0,      0,            A_MISA,  8'h0, 0, 32'h4000_0100, 0,             0,             32'h1800, 0));
      tbl.push_back(mk("hartid",   0, 0,      0,            0, 0,      0,            32'hF14, 8'h0, 0, 32'h0,         0,             0,             32'h1800, 0));
      tbl.push_back(mk("vendor",   0, 0,      0,            0, 0,      0,            32'hF11, 8'h0, 0, 32'h0,         0,             0,             32'h1800, 0));
      tbl.push_back(mk("trap_epc", 0, 0,      0,            1, A_MEPC, 32'h8000_0106, A_MEPC, 8'h0, 0, 32'h8000_0104, 0,             0,             32'h1800, 0));
      tbl.push_back(mk("trap_mst", 0, 0,      0,            1, A_MST,  32'h1808,     A_MEPC,  8'h0, 0, 32'h8000_0104, 0,             32'h8000_0104, 32'h1800, 0));
      tbl.push_back(mk("trap_mca", 0, 0,      0,            1, A_MCA,  32'h8000_0004, A_MST,  8'h0, 0, 32'h1808,      0,             32'h8000_0104, 32'h1808, 1));
      tbl.push_back(mk("rd_mca",   0, 0,      0,            0, 0,      0,            A_MCA,   8'h0, 0, 32'h8000_0004, 0,             32'h8000_0104, 32'h1808, 1));
      tbl.push_back(mk("coll_same",1, A_MSC,  32'h11,       1, A_MSC,  32'h22,       A_MSC,   8'h0, 0, 32'h22,        0,             32'h8000_0104, 32'h1808, 1));
      tbl.push_back(mk("rd_msc1",  0, 0,      0,            0, 0,      0,            A_MSC,   8'h0, 0, 32'h22,        0,             32'h8000_0104, 32'h1808, 1));
      tbl.push_back(mk("coll_diff",1, A_MSC,  32'h11,       1, A_MEPC, 32'h40,       A_MSC,   8'h0, 0, 32'h11,        0,             32'h8000_0104, 32'h1808, 1));
      tbl.push_back(mk("rd_mepc",  0, 0,      0,            0, 0,      0,            A_MEPC,  8'h0, 0, 32'h40,        0,             32'h40,        32'h1808, 1));
      tbl.push_back(mk("rd_msc2",  0, 0,      0,            0, 0,      0,            A_MSC,   8'h0, 0, 32'h11,        0,             32'h40,        32'h1808, 1));
      tbl.push_back(mk("byp_mtv",  1, A_MTV,  32'h8000_0100, 0, 0,     0,            A_MTV,   8'h0, 0, 32'h8000_0100, 0,             32'h40,        32'h1808, 1));
      tbl.push_back(mk("rd_mtv",   0, 0,      0,            0, 0,      0,            A_MTV,   8'h0, 0, 32'h8000_0100, 32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("ill_wr",   1, 32'h1305, 32'hDEAD,   0, 0,      0,            32'h1305, 8'h0, 0, 32'h0,        32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("ill_chk",  0, 0,      0,            0, 0,      0,            A_MTV,   8'h0, 0, 32'h8000_0100, 32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("ro_misa",  0, 0,      0,            1, A_MISA, 32'hFFFF_FFFF, A_MISA, 8'h0, 0, 32'h4000_0100, 32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("ro_chk",   0, 0,      0,            0, 0,      0,            A_MISA,  8'h0, 0, 32'h4000_0100, 32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("mip",      1, A_MIP,  32'hFF,       0, 0,      0,            A_MIP,   8'h80, 0, 32'h80,       32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("unimpl",   1, 32'h123, 32'h5,       0, 0,      0,            32'h123, 8'h0, 0, 32'h0,         32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("wr_mie",   1, A_MIE,  32'h888,      0, 0,      0,            A_MIE,   8'h0, 0, 32'h888,       32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("rd_mie",   0, 0,      0,            0, 0,      0,            A_MIE,   8'h0, 0, 32'h888,       32'h8000_0100, 32'h40,        32'h1808, 1));
      tbl.push_back(mk("ex_mepc",  1, A_MEPC, 32'h7,        0, 0,      0,            A_MEPC,  8'h0, 0, 32'h4,         32'h8000_0100, 32'h40,        32'h1808, 1));

      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) run(tbl[i]);

      // ---- counters -------------------------------------------------------
      s_mtvec = 32'h8000_0100; s_mepc = 32'h4; s_mstatus = 32'h1808; s_gie = 1'b1;
      run(hs("mcycle_now", 0, 0, 0, 0, 0, 0, A_CYC, 0, cyc));
      run(hs("minstret_idle", 0, 0, 0, 0, 0, 0, A_INS, 0, 32'h0));
      run(hs("ret0", 0, 0, 0, 0, 0, 0, A_INS, 1, 32'h0));
      run(hs("ret1", 0, 0, 0, 0, 0, 0, A_INS, 1, 32'h1));
      run(hs("ret2", 0, 0, 0, 0, 0, 0, A_INS, 1, 32'h2));
      run(hs("ret_hold", 0, 0, 0, 0, 0, 0, A_INS, 0, 32'h3));
      run(hs("ret_hold2", 0, 0, 0, 0, 0, 0, A_INS, 0, 32'h3));
      run(hs("ins_wr", 1, A_INS, 32'd10, 0, 0, 0, A_INS, 1, 32'd10));
      run(hs("ins_t1", 0, 0, 0, 0, 0, 0, A_INS, 1, 32'd10));
      run(hs("ins_t2", 0, 0, 0, 0, 0, 0, A_INS, 0, 32'd11));
      run(hs("ins_hi", 0, 0, 0, 0, 0, 0, A_INSH, 0, 32'h0));
      run(hs("cyc_wr", 1, A_CYC, 32'hFFFF_FFFF, 1, A_CYCH, 32'h5, A_CYCH, 0, 32'h5));
      run(hs("cyc_lo_t1", 0, 0, 0, 0, 0, 0, A_CYC, 0, 32'hFFFF_FFFF));
      run(hs("cyc_lo_t2", 0, 0, 0, 0, 0, 0, A_CYC, 0, 32'h0));
      run(hs("cyc_hi_t3", 0, 0, 0, 0, 0, 0, A_CYCH, 0, 32'h6));
      run(hs("cyc_hiwr", 0, 0, 0, 1, A_CYCH, 32'h9, A_CYCH, 0, 32'h9));
      run(hs("cyc_hi_chk", 0, 0, 0, 0, 0, 0, A_CYCH, 0, 32'h9));

      // ---- reset in the middle of a write ---------------------------------
      ex_we_i = 1'b1;  ex_waddr_i = A_MSC; ex_wdata_i = 32'h99;
      int_we_i = 1'b1; int_waddr_i = A_MST; int_wdata_i = 32'h8;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst.mstatus", mstatus_o, 32'h1800);
      chk("async_rst.mepc", mepc_o, 32'h0);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      s_mtvec = 32'h0; s_mepc = 32'h0; s_mstatus = 32'h1800; s_gie = 1'b0;
      run(hs("post_msc", 0, 0, 0, 0, 0, 0, A_MSC, 0, 32'h0));
      run(hs("post_mst", 0, 0, 0, 0, 0, 0, A_MST, 0, 32'h1800));
      run(hs("post_mie", 0, 0, 0, 0, 0, 0, A_MIE, 0, 32'h0));
      run(hs("post_cyc", 0, 0, 0, 0, 0, 0, A_CYC, 0, 32'h3));
      run(hs("post_cych", 0, 0, 0, 0, 0, 0, A_CYCH, 0, 32'h0));

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
